alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 2, meaning the number of requester ports; only the value 2 is supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation on requester N is accepted this cycle.
REQ-006 reqN_opcode  input  7  RV32I opcode of the operation.
REQ-007 reqN_funct3  input  3  RV32I funct3.
REQ-008 reqN_funct7_bit5  input  1  instruction bit 30.
REQ-009 reqN_a  input  32  operand A.
REQ-010 reqN_b  input  32  operand B, either rs2 or the immediate.
REQ-011 rspN_valid  output  1  the result for requester N is held.
REQ-012 rspN_ready  input  1  requester N consumes its result.
REQ-013 rspN_result  output  32  registered ALU result.
REQ-014 op_count  output  32  count of accepted operations.

Function
REQ-015 Requester N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-016 At most one requester SHALL be granted per cycle, and the grant SHALL be combinational from the current inputs and state.
REQ-017 If exactly one requester is eligible, it SHALL be granted.
REQ-018 If both are eligible, the requester not named by last_grant SHALL be granted (round-robin).
REQ-019 reqN_ready SHALL be 1 only when requester N is granted, and it SHALL NOT depend on reqN_ready of either port.
REQ-020 last_grant SHALL update to N only on a cycle where reqN_valid and reqN_ready are both 1.
REQ-021 The ALU control SHALL use the shared 4-bit encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
REQ-022 Operation selection for R-type and I-type opcodes:
- funct3=000 SHALL select SUB only for R-type with funct7_bit5=1; otherwise ADD.
- funct3=101 SHALL select SRA when funct7_bit5=1; otherwise SRL.
REQ-023 Any other opcode SHALL select ADD.
REQ-024 ADD and SUB SHALL wrap modulo 2^32.
REQ-025 Shifts SHALL use b[4:0] only; SRA SHALL replicate a[31].
REQ-026 SLT SHALL compare signed and SLTU unsigned, each producing 32'd0 or 32'd1.
REQ-027 Latency SHALL be 1 cycle: an operation accepted at edge t SHALL produce rspN_valid=1 with rspN_result from edge t onward.
REQ-028 rspN_result SHALL hold stable while rspN_valid=1 and rspN_ready=0.
REQ-029 rspN_valid SHALL clear on a cycle with rspN_ready=1 and no new acceptance for N.
REQ-030 Simultaneous drain and accept on the same port SHALL keep rspN_valid=1 and load the new result, giving back-to-back throughput of 1 op/cycle.
REQ-031 op_count SHALL increment by 1 per acceptance and wrap from 32'hFFFFFFFF to 0.
REQ-032 The arbiter SHALL be a 2-state FSM on last_grant (LAST0, LAST1), with transitions only per REQ-020.

Reset
REQ-033 rst=1 at a clock edge SHALL, on that edge, set rspN_valid=0, rspN_result=0, op_count=0, and last_grant=LAST1, so that requester 0 wins the first tie.
REQ-034 While rst=1, reqN_ready SHALL be 0.
REQ-035 Reset during any activity SHALL discard pending results without producing a response.

Structure
REQ-036 Package alu_pkg SHALL hold:
- the opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011;
- the alu_control enum typedef (4-bit);
- the 32-bit data width constant.
REQ-037 One combinational sub-module, alu_core (inputs alu_control, a, b; output result), SHALL be instantiated once; the existing ALU decoder SHALL feed it from the granted requester's fields.

Verification
REQ-038 The bench SHALL cover:
- Only req0: ADD a=5, b=7 -> req0_ready=1; next cycle rsp0_valid=1, rsp0_result=12; op_count=1.
- Both eligible for 4 consecutive cycles (after reset) -> grants 0,1,0,1.
- R-type funct3=000, funct7_bit5=1, a=3, b=5 -> result 32'hFFFFFFFE. I-type with the same fields -> result 8.
- SRA a=32'h80000000, b=32'h00000024 -> result 32'hF8000000. SLTU a=1, b=32'hFFFFFFFF -> 1. SLT with the same operands -> 0.
- rsp0_ready=0 with rsp0_valid=1 and req0 valid -> req0_ready=0 while req1 is still granted. Raising rsp0_ready -> same-cycle accept and reload per REQ-030.
- Assert rst mid-stream with both responses pending -> next cycle rspN_valid=0, op_count=0, and the first tie is granted to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Pure declarations, no logic or latency.
// No flow control here; the decoder helper is combinational.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_control_t;

  // Round-robin memory: which requester was accepted most recently.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_grant_t;

  // RV32I OP / OP-IMM decoder. SUB exists only for R-type; SRA is picked by
  // instruction bit 30 for both forms. Anything that is not OP/OP-IMM adds.
  function automatic alu_control_t alu_decode(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic       funct7_bit5);
    alu_control_t ctl;
    ctl = ALU_ADD;
    if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
      case (funct3)
        3'b000:  ctl = (opcode == OP_RTYPE && funct7_bit5) ? ALU_SUB : ALU_ADD;
        3'b001:  ctl = ALU_SLL;
        3'b010:  ctl = ALU_SLT;
        3'b011:  ctl = ALU_SLTU;
        3'b100:  ctl = ALU_XOR;
        3'b101:  ctl = funct7_bit5 ? ALU_SRA : ALU_SRL;
        3'b110:  ctl = ALU_OR;
        default: ctl = ALU_AND;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both requester ports of the ALU arbiter.
// Wiring only, no latency.
// Each port uses valid/ready on requests and valid/ready on responses.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [6:0]        req0_opcode;
  logic [2:0]        req0_funct3;
  logic              req0_funct7_bit5;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;

  logic              req1_valid;
  logic              req1_ready;
  logic [6:0]        req1_opcode;
  logic [2:0]        req1_funct3;
  logic              req1_funct7_bit5;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;

  // Requester side: issues operations, consumes results.
  modport master (
    output req0_valid, req0_opcode, req0_funct3, req0_funct7_bit5, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_opcode, req1_funct3, req1_funct7_bit5, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result
  );

  // Arbiter side: accepts operations, holds results.
  modport slave (
    input  req0_valid, req0_opcode, req0_funct3, req0_funct7_bit5, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_opcode, req1_funct3, req1_funct7_bit5, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result
  );

endinterface

// File: rtl/alu_core.sv
// Combinational RV32I integer ALU selected by a 4-bit control code.
// Zero latency; purely combinational.
// No flow control; caller registers the result.
module alu_core
  import alu_pkg::*;
(
  input  alu_control_t      alu_control,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Result mux; unused control codes fall back to addition.
  always_comb begin
    result = a + b;
    case (alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter; results are registered per port.
// Latency 1 cycle: an op accepted at edge t is visible on rspN_* from edge t onward.
// A port is not granted while its held result is unconsumed, unless it is drained the same cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2  // only 2 is supported
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] op_count
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  last_grant_t        state;
  last_grant_t        state_nxt;

  logic              accept0;
  logic              accept1;
  logic [6:0]        sel_opcode;
  logic [2:0]        sel_funct3;
  logic              sel_funct7_bit5;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  alu_control_t      alu_ctl;
  logic [DATA_W-1:0] alu_result;

  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_result_q;
  logic [DATA_W-1:0] rsp1_result_q;

  // A port may take a new op if its result slot is empty or is being drained now.
  assign elig[0] = bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
  assign elig[1] = bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);

  // Round-robin memory; reset favours requester 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst) state <= LAST1;
    else     state <= state_nxt;
  end

  // Grant selection and next round-robin state; nothing is granted during reset.
  always_comb begin
    grant     = '0;
    state_nxt = state;
    if (!rst) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (state == LAST1) ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
    // A grant always coincides with valid, so a grant is an acceptance.
    if (grant[0])      state_nxt = LAST0;
    else if (grant[1]) state_nxt = LAST1;
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign accept0        = bus.req0_valid & grant[0];
  assign accept1        = bus.req1_valid & grant[1];

  // Route the granted requester's fields into the shared decoder and ALU.
  always_comb begin
    sel_opcode      = bus.req0_opcode;
    sel_funct3      = bus.req0_funct3;
    sel_funct7_bit5 = bus.req0_funct7_bit5;
    sel_a           = bus.req0_a;
    sel_b           = bus.req0_b;
    if (grant[1]) begin
      sel_opcode      = bus.req1_opcode;
      sel_funct3      = bus.req1_funct3;
      sel_funct7_bit5 = bus.req1_funct7_bit5;
      sel_a           = bus.req1_a;
      sel_b           = bus.req1_b;
    end
    alu_ctl = alu_decode(sel_opcode, sel_funct3, sel_funct7_bit5);
  end

  alu_core u_alu_core (
    .alu_control (alu_ctl),
    .a           (sel_a),
    .b           (sel_b),
    .result      (alu_result)
  );

  // Port 0 result slot: load on accept (even while draining), clear on drain alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
    end else if (accept0) begin
      rsp0_valid_q  <= 1'b1;
      rsp0_result_q <= alu_result;
    end else if (bus.rsp0_ready) begin
      rsp0_valid_q  <= 1'b0;
    end
  end

  // Port 1 result slot: same policy as port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
    end else if (accept1) begin
      rsp1_valid_q  <= 1'b1;
      rsp1_result_q <= alu_result;
    end else if (bus.rsp1_ready) begin
      rsp1_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_result = rsp1_result_q;

  // Accepted-operation counter; at most one acceptance per cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                    op_count <= '0;
    else if (accept0 | accept1) op_count <= op_count + 32'd1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed check of alu_arbiter against a behavioural model.
// Inputs change just after the falling edge; ready is sampled 1 ns later, registered outputs at the next falling edge.
// Response backpressure is exercised by randomly dropping rspN_ready.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_count;

  alu_arbiter_if bus ();

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stimulus per requester.
  logic        v  [2];
  logic        rr [2];
  logic [6:0]  op [2];
  logic [2:0]  f3 [2];
  logic        f7 [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];

  // Reference state.
  bit          m_pend [2];
  logic [31:0] m_res  [2];
  logic [31:0] m_cnt;
  int          m_last;

  // Spec-level ALU: plain arithmetic, no shared decoder.
  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] fn3,
                                          input logic fn7, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ones;
    int unsigned sh;
    bit rt, it;
    ones = 32'hFFFFFFFF;
    sh   = y % 32;
    rt   = (opc == 7'b0110011);
    it   = (opc == 7'b0010011);
    if (!(rt || it)) return x + y;
    case (fn3)
      3'd0: return (rt && fn7) ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ((x ^ 32'h80000000) < (y ^ 32'h80000000)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return fn7 ? ((x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0)) : (x >> sh);
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic int model_grant();
    bit e0, e1;
    if (rst) return -1;
    e0 = v[0] && (!m_pend[0] || rr[0]);
    e1 = v[1] && (!m_pend[1] || rr[1]);
    if (e0 && e1) return (m_last == 1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_pend[n] = 0;
        m_res[n]  = 32'd0;
      end
      m_cnt  = 32'd0;
      m_last = 1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g == n) begin
          m_pend[n] = 1;
          m_res[n]  = ref_alu(op[n], f3[n], f7[n], a[n], b[n]);
        end else if (rr[n]) begin
          m_pend[n] = 0;
        end
      end
      if (g >= 0) begin
        m_cnt  = m_cnt + 32'd1;
        m_last = g;
      end
    end
  endtask

  task automatic apply();
    bus.req0_valid = v[0]; bus.req0_opcode = op[0]; bus.req0_funct3 = f3[0];
    bus.req0_funct7_bit5 = f7[0]; bus.req0_a = a[0]; bus.req0_b = b[0]; bus.rsp0_ready = rr[0];
    bus.req1_valid = v[1]; bus.req1_opcode = op[1]; bus.req1_funct3 = f3[1];
    bus.req1_funct7_bit5 = f7[1]; bus.req1_a = a[1]; bus.req1_b = b[1]; bus.rsp1_ready = rr[1];
  endtask

  // One clock: check grants, advance model, check registered outputs.
  task automatic step(output logic [1:0] rdy);
    int g;
    apply();
    #1;
    g   = model_grant();
    rdy = {bus.req1_ready, bus.req0_ready};
    chk("ready0", 32'(bus.req0_ready), 32'(g == 0));
    chk("ready1", 32'(bus.req1_ready), 32'(g == 1));
    @(posedge clk);
    model_update(g);
    @(negedge clk);
    chk("rsp0_valid",  32'(bus.rsp0_valid), 32'(m_pend[0]));
    chk("rsp0_result", bus.rsp0_result, m_res[0]);
    chk("rsp1_valid",  32'(bus.rsp1_valid), 32'(m_pend[1]));
    chk("rsp1_result", bus.rsp1_result, m_res[1]);
    chk("op_count",    op_count, m_cnt);
  endtask

  task automatic set_req(input int n, input logic vv, input logic [6:0] o, input logic [2:0] fn3,
                         input logic fn7, input logic [31:0] x, input logic [31:0] y);
    v[n] = vv; op[n] = o; f3[n] = fn3; f7[n] = fn7; a[n] = x; b[n] = y;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [1:0] rdy;
  logic [1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    m_cnt = 32'd0; m_last = 1;
    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 0; m_res[n] = 32'd0; rr[n] = 1'b0;
      set_req(n, 1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    end

    // Reset with requests present: no grants while rst is high.
    rst = 1'b1;
    set_req(0, 1'b1, OP_RTYPE, 3'd0, 1'b0, 32'd1, 32'd1);
    step(rdy);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_count", op_count, 32'd0);
    chk("rst_valid0", 32'(bus.rsp0_valid), 32'd0);
    rst = 1'b0;

    // Both eligible right after reset: 0,1,0,1.
    rr[0] = 1'b1; rr[1] = 1'b1;
    set_req(0, 1'b1, OP_RTYPE, 3'd0, 1'b0, 32'd1, 32'd2);
    set_req(1, 1'b1, OP_RTYPE, 3'd0, 1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(rdy);
      chk("rr_seq", 32'(rdy), 32'(exp_seq[i]));
    end

    // Fresh reset, then a lone ADD on requester 0.
    rst = 1'b1;
    set_req(0, 1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    step(rdy);
    rst = 1'b0;
    rr[0] = 1'b0; rr[1] = 1'b0;
    set_req(0, 1'b1, OP_RTYPE, 3'd0, 1'b0, 32'd5, 32'd7);
    step(rdy);
    chk("add_ready", 32'(rdy), 32'b01);
    chk("add_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("add_result", bus.rsp0_result, 32'd12);
    chk("add_count", op_count, 32'd1);

    // Directed ALU cases, each accepted while the previous result drains.
    rr[0] = 1'b1;
    set_req(0, 1'b1, OP_RTYPE, 3'b000, 1'b1, 32'd3, 32'd5);
    step(rdy);
    chk("sub_r", bus.rsp0_result, 32'hFFFFFFFE);
    set_req(0, 1'b1, OP_ITYPE, 3'b000, 1'b1, 32'd3, 32'd5);
    step(rdy);
    chk("addi_bit30", bus.rsp0_result, 32'd8);
    set_req(0, 1'b1, OP_RTYPE, 3'b101, 1'b1, 32'h80000000, 32'h00000024);
    step(rdy);
    chk("sra", bus.rsp0_result, 32'hF8000000);
    set_req(0, 1'b1, OP_RTYPE, 3'b011, 1'b0, 32'd1, 32'hFFFFFFFF);
    step(rdy);
    chk("sltu", bus.rsp0_result, 32'd1);
    set_req(0, 1'b1, OP_RTYPE, 3'b010, 1'b0, 32'd1, 32'hFFFFFFFF);
    step(rdy);
    chk("slt", bus.rsp0_result, 32'd0);
    chk("bb_valid", 32'(bus.rsp0_valid), 32'd1);

    // Port 0 result held and not consumed: only port 1 may be granted.
    rr[0] = 1'b0; rr[1] = 1'b1;
    set_req(0, 1'b1, OP_RTYPE, 3'b000, 1'b0, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_RTYPE, 3'b000, 1'b0, 32'd2, 32'd2);
    step(rdy);
    chk("bp_ready", 32'(rdy), 32'b10);
    chk("bp_hold", bus.rsp0_result, 32'd0);
    chk("bp_r1", bus.rsp1_result, 32'd4);
    // Drain and accept on port 0 in the same cycle.
    rr[0] = 1'b1;
    step(rdy);
    chk("reload_ready", 32'(rdy), 32'b01);
    chk("reload_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("reload_result", bus.rsp0_result, 32'd2);

    // Make both results pending, then reset mid-stream.
    rr[0] = 1'b0; rr[1] = 1'b0;
    v[0] = 1'b0;
    step(rdy);
    chk("pend_both", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b11);
    rst = 1'b1;
    v[0] = 1'b1; v[1] = 1'b1;
    step(rdy);
    chk("mid_rst_ready", 32'(rdy), 32'd0);
    chk("mid_rst_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    chk("mid_rst_count", op_count, 32'd0);
    rst = 1'b0;
    rr[0] = 1'b1; rr[1] = 1'b1;
    step(rdy);
    chk("post_rst_tie", 32'(rdy), 32'b01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int n = 0; n < 2; n++) begin
        v[n]  = ($urandom_range(0, 3) != 0);
        rr[n] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0, 1:    op[n] = OP_RTYPE;
          2:       op[n] = OP_ITYPE;
          default: op[n] = 7'($urandom);
        endcase
        f3[n] = 3'($urandom);
        f7[n] = 1'($urandom);
        a[n]  = rnd_val();
        b[n]  = rnd_val();
      end
      step(rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
